pipeline_hazard_ctrl: RTL and testbench
=======================================

// Module: pipeline_hazard_ctrl
// PURPOSE
//  Central stall/flush sequencer for the 5-stage core (IF/ID/EX/MEM/WB).
//  - Drives one clock enable per pipeline register; detects RAW hazards on the ID-stage source registers.
//  - Squashes IF/ID on a branch taken in ID; freezes the pipe during data-memory wait states.
//  - Flags a bus timeout and counts stall cycles for performance monitoring.
// PARAMETERS
//  TIMEOUT_CYC  256  cycles of dmem_req without dmem_ready before timeout; must be >=2
//  CNT_W        32   width of stall_cnt
// PORTS
//  clk            in   1      clock
//  rst_n          in   1      reset, asynchronous, active-low
//  id_valid       in   1      ID holds a real instruction (not a bubble)
//  id_rs1_addr    in   5      ID source register 1 address
//  id_rs2_addr    in   5      ID source register 2 address
//  id_rs1_used    in   1      ID instruction reads rs1
//  id_rs2_used    in   1      ID instruction reads rs2
//  id_branch_taken in  1      jump decision in ID resolved taken
//  ex_rd_addr     in   5      EX destination register
//  ex_rd_wr_en    in   1      EX writes rd
//  ex_data_rd_en  in   1      EX instruction is a load
//  mem_rd_addr    in   5      MEM destination register
//  mem_rd_wr_en   in   1      MEM writes rd
//  wb_rd_addr     in   5      WB destination register
//  wb_rd_wr_en    in   1      WB writes rd
//  dmem_req       in   1      MEM stage data access outstanding
//  dmem_ready     in   1      data memory completes access this cycle
//  if_clk_en      out  1      PC and IF/ID register enable
//  id_clk_en      out  1      ID/EX register enable
//  ex_clk_en      out  1      EX/MEM register enable
//  mem_clk_en     out  1      MEM/WB register enable
//  id_bubble      out  1      load a NOP into ID/EX (all control bits zero)
//  if_flush       out  1      load a NOP into IF/ID
//  bus_err        out  1      sticky dmem timeout flag
//  stall_cnt      out  CNT_W  cycles in which if_clk_en=0
// BEHAVIOUR
//  - Reset: state=RUN, tmo counter=0, stall_cnt=0, bus_err=0.
//  - All outputs combinational from state and inputs; no added latency.
//  - hazard = id_valid & any used rsN!=x0 matching an enabled producer (see CONFIGURATION).
//  - FSM states: RUN, HAZ, MWAIT, ERR.
//    - RUN->MWAIT: dmem_req & !dmem_ready.
//    - RUN->HAZ: hazard.
//    - HAZ->RUN: !hazard.
//    - MWAIT->RUN: dmem_ready.
//    - MWAIT->ERR: tmo == TIMEOUT_CYC-1.
//    - ERR: terminal until rst_n.
//  - Priority per cycle: ERR > dmem wait > hazard > branch. Transitions are evaluated from RUN or HAZ using the same order.
//  - Dmem wait (dmem_req & !dmem_ready, or ERR): all four clk_en=0; id_bubble=0; if_flush=0.
//  - Hazard: if_clk_en=0, id_clk_en=1, id_bubble=1, ex/mem_clk_en=1. ID holds; a bubble enters EX.
//  - Branch (no hazard, no wait): all enables=1, if_flush=1. A branch whose operands are hazarded waits for the hazard to clear.
//  - Otherwise: all enables=1, flush/bubble=0.
//  - tmo counter: increments each MWAIT cycle; cleared on leaving MWAIT.
//  - dmem_ready in the first cycle of dmem_req: no wait cycle, no stall.
//  - stall_cnt: +1 each cycle if_clk_en=0; saturates at all-ones.
//  - Async reset mid-stall: returns to RUN; pipeline registers are reset by their owners.
// CONFIGURATION
//  FORWARDING_EN defined:
//    - EX->ID and MEM->ID bypass exists.
//    - Hazard only when ex_rd_wr_en & ex_data_rd_en & ex_rd_addr matches (load-use, 1 bubble).
//  FORWARDING_EN undefined:
//    - Hazard on any match with EX, MEM or WB enabled producers (reg file has no write-through).
//    - Up to 3 bubbles.
// STRUCTURE
//  - riscv_definitions: add hzdState_e {RUN,HAZ,MWAIT,ERR} and regAddr_t (logic [4:0]).
//  - Single module; a src_match() function replaces any sub-module.
// TESTING
//  - Load-use: EX load to x5, ID add using x5 (FORWARDING_EN) -> 1 cycle if_clk_en=0, id_bubble=1, then RUN; stall_cnt=1.
//  - No fwd: MEM writes x7, ID reads x7 -> stall 2 cycles until WB retires; x0 match never stalls.
//  - Branch: id_branch_taken=1, no hazard -> if_flush=1 for 1 cycle, all enables=1.
//  - Dmem wait: dmem_req, ready after 3 cycles -> all enables 0 for 3 cycles; hazard + wait together -> wait wins, id_bubble=0.
//  - Timeout: TIMEOUT_CYC=4, ready never -> bus_err=1 in cycle 5, stays 1; rst_n low -> 0, RUN.
//  - Saturation: CNT_W=4, 20 stall cycles -> stall_cnt=15.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_hazard_ctrl_pkg
// Description : Shared types and helpers for the pipeline hazard sequencer.
//               hzdState_e - sequencer states (RUN, HAZ, MWAIT, ERR).
//               regAddr_t  - 5-bit architectural register address.
//               src_match  - one source-operand / producer dependency test.
// Revision    : 1.0 - initial release
// ============================================================================
package pipeline_hazard_ctrl_pkg;

  typedef logic [4:0] regAddr_t;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    HAZ   = 2'd1,
    MWAIT = 2'd2,
    ERR   = 2'd3
  } hzdState_e;

  localparam regAddr_t REG_X0 = 5'd0;

  // True when a source operand that is actually read depends on a producer
  // that will write it. x0 is hardwired to zero, so it never creates a
  // dependency.
  function automatic logic src_match(
    input regAddr_t src,
    input logic     used,
    input regAddr_t dst,
    input logic     wr_en
  );
    return used && wr_en && (src != REG_X0) && (src == dst);
  endfunction

endpackage : pipeline_hazard_ctrl_pkg
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_hazard_ctrl_if
// Description : Bundle between the 5-stage pipeline and the hazard sequencer.
//               master : pipeline side, drives stage status and dmem status,
//                        receives register enables, bubble and flush.
//               slave  : hazard sequencer side (inverse directions).
// Revision    : 1.0 - initial release
// ============================================================================
interface pipeline_hazard_ctrl_if;
  import pipeline_hazard_ctrl_pkg::*;

  // ID stage
  logic     id_valid;
  regAddr_t id_rs1_addr;
  regAddr_t id_rs2_addr;
  logic     id_rs1_used;
  logic     id_rs2_used;
  logic     id_branch_taken;
  // Producers in later stages
  regAddr_t ex_rd_addr;
  logic     ex_rd_wr_en;
  logic     ex_data_rd_en;
  regAddr_t mem_rd_addr;
  logic     mem_rd_wr_en;
  regAddr_t wb_rd_addr;
  logic     wb_rd_wr_en;
  // Data memory status
  logic     dmem_req;
  logic     dmem_ready;
  // Pipeline register control
  logic     if_clk_en;
  logic     id_clk_en;
  logic     ex_clk_en;
  logic     mem_clk_en;
  logic     id_bubble;
  logic     if_flush;

  modport master (
    output id_valid, id_rs1_addr, id_rs2_addr, id_rs1_used, id_rs2_used,
           id_branch_taken, ex_rd_addr, ex_rd_wr_en, ex_data_rd_en,
           mem_rd_addr, mem_rd_wr_en, wb_rd_addr, wb_rd_wr_en,
           dmem_req, dmem_ready,
    input  if_clk_en, id_clk_en, ex_clk_en, mem_clk_en, id_bubble, if_flush
  );

  modport slave (
    input  id_valid, id_rs1_addr, id_rs2_addr, id_rs1_used, id_rs2_used,
           id_branch_taken, ex_rd_addr, ex_rd_wr_en, ex_data_rd_en,
           mem_rd_addr, mem_rd_wr_en, wb_rd_addr, wb_rd_wr_en,
           dmem_req, dmem_ready,
    output if_clk_en, id_clk_en, ex_clk_en, mem_clk_en, id_bubble, if_flush
  );

endinterface : pipeline_hazard_ctrl_if
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_hazard_ctrl
// Description : Central stall/flush sequencer for the IF/ID/EX/MEM/WB core.
//               Generates one enable per pipeline register, inserts a bubble
//               into ID/EX on RAW hazards, flushes IF/ID on a taken branch,
//               freezes the pipe during dmem wait states, flags a dmem
//               timeout and counts cycles with the front end stalled.
// Ports       : clk        - clock
//               rst_n      - asynchronous active-low reset
//               pipe       - pipeline_hazard_ctrl_if.slave bundle
//               bus_err    - sticky dmem timeout flag (cleared by rst_n only)
//               stall_cnt  - saturating count of cycles with if_clk_en=0
// Parameters  : TIMEOUT_CYC - MWAIT cycles without dmem_ready before ERR (>=2)
//               CNT_W       - width of stall_cnt
// Macros      : FORWARDING_EN - EX/MEM->ID bypass present; only load-use
//               hazards stall. Undefined: any EX/MEM/WB producer match stalls.
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYC = 256,
  parameter int CNT_W       = 32
) (
  input  wire                      clk,
  input  wire                      rst_n,
  pipeline_hazard_ctrl_if.slave    pipe,
  output logic                     bus_err,
  output logic [CNT_W-1:0]         stall_cnt
);

  localparam int TMO_W = $clog2(TIMEOUT_CYC);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

  hzdState_e        state;
  hzdState_e        state_next;
  logic [TMO_W-1:0] tmo;
  logic             hazard;
  logic             dmem_wait;
  logic             freeze;

  // --------------------------------------------------------------------------
  // RAW hazard detection
  // --------------------------------------------------------------------------
`ifdef FORWARDING_EN
  // EX and MEM results are bypassed into ID; only a load still in EX has no
  // data yet, so that is the single case needing a bubble.
  logic ex_load;
  logic unused_no_bypass_producers;

  assign ex_load = pipe.ex_rd_wr_en & pipe.ex_data_rd_en;
  assign hazard  = pipe.id_valid &
                   (src_match(pipe.id_rs1_addr, pipe.id_rs1_used, pipe.ex_rd_addr, ex_load) |
                    src_match(pipe.id_rs2_addr, pipe.id_rs2_used, pipe.ex_rd_addr, ex_load));
  assign unused_no_bypass_producers = ^{pipe.mem_rd_addr, pipe.mem_rd_wr_en,
                                        pipe.wb_rd_addr, pipe.wb_rd_wr_en};
`else
  // No bypass and no register-file write-through: ID must wait until the
  // producer has left WB, whatever kind of instruction it is.
  logic rs1_dep;
  logic rs2_dep;
  logic unused_load_flag;

  assign rs1_dep = src_match(pipe.id_rs1_addr, pipe.id_rs1_used, pipe.ex_rd_addr,  pipe.ex_rd_wr_en)  |
                   src_match(pipe.id_rs1_addr, pipe.id_rs1_used, pipe.mem_rd_addr, pipe.mem_rd_wr_en) |
                   src_match(pipe.id_rs1_addr, pipe.id_rs1_used, pipe.wb_rd_addr,  pipe.wb_rd_wr_en);
  assign rs2_dep = src_match(pipe.id_rs2_addr, pipe.id_rs2_used, pipe.ex_rd_addr,  pipe.ex_rd_wr_en)  |
                   src_match(pipe.id_rs2_addr, pipe.id_rs2_used, pipe.mem_rd_addr, pipe.mem_rd_wr_en) |
                   src_match(pipe.id_rs2_addr, pipe.id_rs2_used, pipe.wb_rd_addr,  pipe.wb_rd_wr_en);
  assign hazard  = pipe.id_valid & (rs1_dep | rs2_dep);
  assign unused_load_flag = pipe.ex_data_rd_en;
`endif

  // A memory access completing in its first cycle never counts as a wait.
  assign dmem_wait = pipe.dmem_req & ~pipe.dmem_ready;
  assign freeze    = (state == ERR) | dmem_wait;

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
    end else begin
      state <= state_next;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state (ERR > dmem wait > hazard)
  // --------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    case (state)
      RUN, HAZ: begin
        if (dmem_wait)   state_next = MWAIT;
        else if (hazard) state_next = HAZ;
        else             state_next = RUN;
      end
      MWAIT: begin
        // Leave as soon as the access is no longer waiting (ready, or the
        // request withdrawn); the timeout only fires while still waiting.
        if (!dmem_wait)           state_next = RUN;
        else if (tmo == TMO_LAST) state_next = ERR;
        else                      state_next = MWAIT;
      end
      ERR:     state_next = ERR;
      default: state_next = RUN;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs, combinational from state and inputs (no added latency)
  // --------------------------------------------------------------------------
  always_comb begin
    pipe.if_clk_en  = 1'b1;
    pipe.id_clk_en  = 1'b1;
    pipe.ex_clk_en  = 1'b1;
    pipe.mem_clk_en = 1'b1;
    pipe.id_bubble  = 1'b0;
    pipe.if_flush   = 1'b0;
    if (freeze) begin
      pipe.if_clk_en  = 1'b0;
      pipe.id_clk_en  = 1'b0;
      pipe.ex_clk_en  = 1'b0;
      pipe.mem_clk_en = 1'b0;
    end else if (hazard) begin
      // ID holds its instruction while a NOP advances into EX.
      pipe.if_clk_en = 1'b0;
      pipe.id_bubble = 1'b1;
    end else if (pipe.id_branch_taken) begin
      pipe.if_flush = 1'b1;
    end
  end

  assign bus_err = (state == ERR);

  // --------------------------------------------------------------------------
  // Timeout counter: counts MWAIT cycles, cleared on leaving MWAIT
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo <= '0;
    end else if ((state == MWAIT) && (state_next == MWAIT)) begin
      tmo <= tmo + 1'b1;
    end else begin
      tmo <= '0;
    end
  end

  // --------------------------------------------------------------------------
  // Stall counter: saturating count of front-end stall cycles
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (!pipe.if_clk_en && !(&stall_cnt)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule : pipeline_hazard_ctrl
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipeline_hazard_ctrl
// Description : Directed self-checking bench for pipeline_hazard_ctrl with
//               TIMEOUT_CYC=4 and CNT_W=4. Control outputs are read as the
//               vector {if_clk_en,id_clk_en,ex_clk_en,mem_clk_en,id_bubble,
//               if_flush}. Inputs change 1ns after a rising edge and outputs
//               are sampled 1ns later.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_hazard_ctrl;

  localparam logic [5:0] CTL_RUN    = 6'b111100;
  localparam logic [5:0] CTL_HAZ    = 6'b011110;
  localparam logic [5:0] CTL_FREEZE = 6'b000000;
  localparam logic [5:0] CTL_BRANCH = 6'b111101;

  logic       clk;
  logic       rst_n;
  logic       bus_err;
  logic [3:0] stall_cnt;
  logic [5:0] ctl;
  int         total;
  int         bad;

  pipeline_hazard_ctrl_if pif ();

  pipeline_hazard_ctrl #(
    .TIMEOUT_CYC (4),
    .CNT_W       (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pipe      (pif.slave),
    .bus_err   (bus_err),
    .stall_cnt (stall_cnt)
  );

  assign ctl = {pif.if_clk_en, pif.id_clk_en, pif.ex_clk_en, pif.mem_clk_en,
                pif.id_bubble, pif.if_flush};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_inputs();
    pif.id_valid = 0; pif.id_rs1_addr = 0; pif.id_rs2_addr = 0;
    pif.id_rs1_used = 0; pif.id_rs2_used = 0; pif.id_branch_taken = 0;
    pif.ex_rd_addr = 0; pif.ex_rd_wr_en = 0; pif.ex_data_rd_en = 0;
    pif.mem_rd_addr = 0; pif.mem_rd_wr_en = 0;
    pif.wb_rd_addr = 0; pif.wb_rd_wr_en = 0;
    pif.dmem_req = 0; pif.dmem_ready = 0;
  endtask

  // Leaves time at 1ns after a rising edge with reset released.
  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 1'b0;
    #3;
    total++; if (ctl !== CTL_RUN) begin bad++; $display("FAIL reset_ctl actual=%b required=%b", ctl, CTL_RUN); end
    total++; if (stall_cnt !== 4'd0) begin bad++; $display("FAIL reset_stall_cnt actual=%0d required=0", stall_cnt); end
    total++; if (bus_err !== 1'b0) begin bad++; $display("FAIL reset_bus_err actual=%b required=0", bus_err); end
  endtask

  task automatic test_hazard();
    do_reset();
`ifdef FORWARDING_EN
    // Load to x5 in EX, ID add reads x5: one bubble.
    pif.id_valid = 1; pif.id_rs1_addr = 5'd5; pif.id_rs1_used = 1;
    pif.ex_rd_addr = 5'd5; pif.ex_rd_wr_en = 1; pif.ex_data_rd_en = 1;
    #1;
    total++; if (ctl !== CTL_HAZ) begin bad++; $display("FAIL load_use_stall actual=%b required=%b", ctl, CTL_HAZ); end
    next_cycle();
    // Bubble now in EX, load moved to MEM and is bypassed.
    pif.ex_rd_wr_en = 0; pif.ex_data_rd_en = 0; pif.ex_rd_addr = 0;
    pif.mem_rd_addr = 5'd5; pif.mem_rd_wr_en = 1;
    #1;
    total++; if (ctl !== CTL_RUN) begin bad++; $display("FAIL load_use_release actual=%b required=%b", ctl, CTL_RUN); end
    next_cycle();
    total++; if (stall_cnt !== 4'd1) begin bad++; $display("FAIL load_use_stall_cnt actual=%0d required=1", stall_cnt); end
    // A non-load producer in EX is bypassed: no stall.
    clear_inputs();
    pif.id_valid = 1; pif.id_rs2_addr = 5'd9; pif.id_rs2_used = 1;
    pif.ex_rd_addr = 5'd9; pif.ex_rd_wr_en = 1;
    #1;
    total++; if (ctl !== CTL_RUN) begin bad++; $display("FAIL alu_fwd_no_stall actual=%b required=%b", ctl, CTL_RUN); end
`else
    // MEM writes x7, ID reads x7: stall until WB retires.
    pif.id_valid = 1; pif.id_rs1_addr = 5'd7; pif.id_rs1_used = 1;
    pif.mem_rd_addr = 5'd7; pif.mem_rd_wr_en = 1;
    #1;
    total++; if (ctl !== CTL_HAZ) begin bad++; $display("FAIL nofwd_mem_stall actual=%b required=%b", ctl, CTL_HAZ); end
    next_cycle();
    pif.mem_rd_wr_en = 0; pif.mem_rd_addr = 0;
    pif.wb_rd_addr = 5'd7; pif.wb_rd_wr_en = 1;
    #1;
    total++; if (ctl !== CTL_HAZ) begin bad++; $display("FAIL nofwd_wb_stall actual=%b required=%b", ctl, CTL_HAZ); end
    next_cycle();
    pif.wb_rd_wr_en = 0; pif.wb_rd_addr = 0;
    #1;
    total++; if (ctl !== CTL_RUN) begin bad++; $display("FAIL nofwd_release actual=%b required=%b", ctl, CTL_RUN); end
    total++; if (stall_cnt !== 4'd2) begin bad++; $display("FAIL nofwd_stall_cnt actual=%0d required=2", stall_cnt); end
    // ALU producer in EX also stalls without forwarding (rs2 path).
    clear_inputs();
    pif.id_valid = 1; pif.id_rs2_addr = 5'd9; pif.id_rs2_used = 1;
    pif.ex_rd_addr = 5'd9; pif.ex_rd_wr_en = 1;
    #1;
    total++; if (ctl !== CTL_HAZ) begin bad++; $display("FAIL nofwd_ex_rs2_stall actual=%b required=%b", ctl, CTL_HAZ); end
`endif
    // x0 never stalls, even against a load writing x0.
    clear_inputs();
    pif.id_valid = 1; pif.id_rs1_used = 1; pif.id_rs2_used = 1;
    pif.ex_rd_wr_en = 1; pif.ex_data_rd_en = 1;
    pif.mem_rd_wr_en = 1; pif.wb_rd_wr_en = 1;
    #1;
    total++; if (ctl !== CTL_RUN) begin bad++; $display("FAIL x0_no_stall actual=%b required=%b", ctl, CTL_RUN); end
    // Matching address on an unused operand does not stall.
    clear_inputs();
    pif.id_valid = 1; pif.id_rs2_addr = 5'd12; pif.id_rs2_used = 0;
    pif.ex_rd_addr = 5'd12; pif.ex_rd_wr_en = 1; pif.ex_data_rd_en = 1;
    #1;
    total++; if (ctl !== CTL_RUN) begin bad++; $display("FAIL unused_rs_no_stall actual=%b required=%b", ctl, CTL_RUN); end
    // A bubble in ID (id_valid=0) does not stall.
    pif.id_rs2_used = 1; pif.id_valid = 0;
    #1;
    total++; if (ctl !== CTL_RUN) begin bad++; $display("FAIL invalid_id_no_stall actual=%b required=%b", ctl, CTL_RUN); end
  endtask

  task automatic test_branch();
    do_reset();
    pif.id_valid = 1; pif.id_branch_taken = 1;
    #1;
    total++; if (ctl !== CTL_BRANCH) begin bad++; $display("FAIL branch_flush actual=%b required=%b", ctl, CTL_BRANCH); end
    next_cycle();
    pif.id_branch_taken = 0;
    #1;
    total++; if (ctl !== CTL_RUN) begin bad++; $display("FAIL branch_one_cycle actual=%b required=%b", ctl, CTL_RUN); end
    // Branch with a hazarded operand waits: no flush yet.
    pif.id_branch_taken = 1; pif.id_rs1_addr = 5'd3; pif.id_rs1_used = 1;
    pif.ex_rd_addr = 5'd3; pif.ex_rd_wr_en = 1; pif.ex_data_rd_en = 1;
    #1;
    total++; if (ctl !== CTL_HAZ) begin bad++; $display("FAIL branch_hazard_waits actual=%b required=%b", ctl, CTL_HAZ); end
  endtask

  task automatic test_dmem_wait();
    do_reset();
    pif.dmem_req = 1; pif.dmem_ready = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++; if (ctl !== CTL_FREEZE) begin bad++; $display("FAIL dmem_freeze_c%0d actual=%b required=%b", i, ctl, CTL_FREEZE); end
      next_cycle();
    end
    pif.dmem_ready = 1;
    #1;
    total++; if (ctl !== CTL_RUN) begin bad++; $display("FAIL dmem_ready_release actual=%b required=%b", ctl, CTL_RUN); end
    next_cycle();
    pif.dmem_req = 0; pif.dmem_ready = 0;
    #1;
    total++; if (stall_cnt !== 4'd3) begin bad++; $display("FAIL dmem_stall_cnt actual=%0d required=3", stall_cnt); end
    // Ready in the first cycle: no wait, no stall.
    pif.dmem_req = 1; pif.dmem_ready = 1;
    #1;
    total++; if (ctl !== CTL_RUN) begin bad++; $display("FAIL dmem_zero_wait actual=%b required=%b", ctl, CTL_RUN); end
    next_cycle();
    pif.dmem_req = 0; pif.dmem_ready = 0;
    #1;
    total++; if (stall_cnt !== 4'd3) begin bad++; $display("FAIL dmem_zero_wait_cnt actual=%0d required=3", stall_cnt); end
    // Hazard and wait together: wait wins, no bubble.
    pif.id_valid = 1; pif.id_rs1_addr = 5'd4; pif.id_rs1_used = 1;
    pif.ex_rd_addr = 5'd4; pif.ex_rd_wr_en = 1; pif.ex_data_rd_en = 1;
    pif.dmem_req = 1;
    #1;
    total++; if (ctl !== CTL_FREEZE) begin bad++; $display("FAIL wait_beats_hazard actual=%b required=%b", ctl, CTL_FREEZE); end
    next_cycle();
    pif.dmem_ready = 1;
    #1;
    total++; if (ctl !== CTL_HAZ) begin bad++; $display("FAIL hazard_after_wait actual=%b required=%b", ctl, CTL_HAZ); end
    next_cycle();
    clear_inputs();
  endtask

  task automatic test_timeout();
    do_reset();
    pif.dmem_req = 1; pif.dmem_ready = 0;
    repeat (4) next_cycle();
    total++; if (bus_err !== 1'b0) begin bad++; $display("FAIL timeout_early actual=%b required=0", bus_err); end
    next_cycle();
    total++; if (bus_err !== 1'b1) begin bad++; $display("FAIL timeout_set actual=%b required=1", bus_err); end
    // Sticky and still frozen after the request goes away.
    pif.dmem_req = 0; pif.dmem_ready = 1;
    next_cycle();
    total++; if (bus_err !== 1'b1) begin bad++; $display("FAIL timeout_sticky actual=%b required=1", bus_err); end
    total++; if (ctl !== CTL_FREEZE) begin bad++; $display("FAIL err_freeze actual=%b required=%b", ctl, CTL_FREEZE); end
    clear_inputs();
    rst_n = 1'b0;
    #1;
    total++; if (bus_err !== 1'b0) begin bad++; $display("FAIL timeout_reset actual=%b required=0", bus_err); end
    total++; if (ctl !== CTL_RUN) begin bad++; $display("FAIL err_reset_ctl actual=%b required=%b", ctl, CTL_RUN); end
    #1 rst_n = 1'b1;
  endtask

  task automatic test_saturation();
    do_reset();
    pif.id_valid = 1; pif.id_rs1_addr = 5'd8; pif.id_rs1_used = 1;
    pif.ex_rd_addr = 5'd8; pif.ex_rd_wr_en = 1; pif.ex_data_rd_en = 1;
    repeat (14) next_cycle();
    total++; if (stall_cnt !== 4'd14) begin bad++; $display("FAIL stall_cnt_14 actual=%0d required=14", stall_cnt); end
    repeat (6) next_cycle();
    total++; if (stall_cnt !== 4'd15) begin bad++; $display("FAIL stall_cnt_sat actual=%0d required=15", stall_cnt); end
    clear_inputs();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_hazard();
    test_branch();
    test_dmem_wait();
    test_timeout();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_pipeline_hazard_ctrl
`default_nettype wire
